bot_evt_sync: RTL and testbench

// - Multi-channel event latch/interrupt-request block; N_CH-channel generalisation of the single
//   bot-update sticky flag (set on update, clear on INT_ACK) between rojobot and the core's GPIO.
// - Per channel: detects events, holds a sticky pending bit until acknowledged, counts events

---
 rtl/bot_evt_pkg.sv | 20 ++
 rtl/bot_evt_chan.sv | 71 +++++++
 rtl/bot_evt_sync.sv | 62 ++++++
 tb/tb_bot_evt_sync.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bot_evt_pkg.sv
// Shared defaults, per-channel state encoding and the saturating increment
// used by the bot event latch block.
package bot_evt_pkg;

    localparam int N_CH_DEF  = 4;
    localparam int CNT_W_DEF = 8;

    typedef enum logic {
        EVT_IDLE = 1'b0,
        EVT_PEND = 1'b1
    } evt_state_e;

    // Increment cnt, holding at the w-bit all-ones value instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int w);
        logic [31:0] max_val;
        max_val = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (cnt >= max_val) ? max_val : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/bot_evt_chan.sv
// One event channel: edge/level event detect, sticky pending flag, and a
// saturating counter of events that arrived while already pending.
//
// state    | meaning
// ---------+---------------------------------------------
// EVT_IDLE | no unacknowledged event
// EVT_PEND | event latched, waiting for software ack
module bot_evt_chan
    import bot_evt_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int EDGE_MODE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             evt_in,
    input  logic             ack,
    input  logic             clr_cnt,
    output logic             pending,
    output logic [CNT_W-1:0] miss_cnt
);

    evt_state_e       state_q;
    evt_state_e       state_d;
    logic             evt;
    logic             miss;
    logic [CNT_W-1:0] cnt_q;

    // History resets high so an input already asserted at reset release is not an event.
    generate
        if (EDGE_MODE != 0) begin : g_edge
            logic evt_q;
            always_ff @(posedge clk) begin
                if (rst) evt_q <= 1'b1;
                else     evt_q <= evt_in;
            end
            assign evt = evt_in & ~evt_q;
        end else begin : g_level
            assign evt = evt_in;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state_q <= EVT_IDLE;
        else     state_q <= state_d;
    end

    // A new event outranks an ack landing in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EVT_IDLE: if (evt)         state_d = EVT_PEND;
            EVT_PEND: if (!evt && ack) state_d = EVT_IDLE;
            default:                   state_d = EVT_IDLE;
        endcase
    end

    always_comb begin
        pending = (state_q == EVT_PEND);
        miss    = evt & pending & ~ack;
    end

    always_ff @(posedge clk) begin
        if (rst)          cnt_q <= '0;
        else if (clr_cnt) cnt_q <= miss ? CNT_W'(1) : '0;
        else if (miss)    cnt_q <= CNT_W'(sat_inc(32'(cnt_q), CNT_W));
    end

    assign miss_cnt = cnt_q;

endmodule

// File: rtl/bot_evt_sync.sv
// Multi-channel sticky event latch with masked, aggregated interrupt request.
// Define BOT_EVT_SYNC_IN_EN to add a 2-flop synchroniser on each i_evt bit.
module bot_evt_sync
    import bot_evt_pkg::*;
#(
    parameter int N_CH      = N_CH_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int EDGE_MODE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         i_evt,
    input  logic [N_CH-1:0]         i_ack,
    input  logic [N_CH-1:0]         i_mask,
    input  logic [N_CH-1:0]         i_clr_cnt,
    output logic [N_CH-1:0]         o_pending,
    output logic                    o_irq,
    output logic [N_CH*CNT_W-1:0]   o_miss_cnt
);

    logic [N_CH-1:0] evt_s;

`ifdef BOT_EVT_SYNC_IN_EN
    // Sync flops reset high so a strobe line idling high is not seen as a rising edge.
    logic [N_CH-1:0] sync1_q;
    logic [N_CH-1:0] sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= i_evt;
            sync2_q <= sync1_q;
        end
    end

    assign evt_s = sync2_q;
`else
    assign evt_s = i_evt;
`endif

    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_chan
            bot_evt_chan #(
                .CNT_W     (CNT_W),
                .EDGE_MODE (EDGE_MODE)
            ) u_chan (
                .clk      (clk),
                .rst      (rst),
                .evt_in   (evt_s[c]),
                .ack      (i_ack[c]),
                .clr_cnt  (i_clr_cnt[c]),
                .pending  (o_pending[c]),
                .miss_cnt (o_miss_cnt[c*CNT_W +: CNT_W])
            );
        end
    endgenerate

    assign o_irq = |(o_pending & ~i_mask);

endmodule

// File: tb/tb_bot_evt_sync.sv
// Bench for bot_evt_sync: three parameterisations driven in lockstep and
// compared every cycle against a behavioural per-channel model.
module tb_bot_evt_sync;

    localparam int W[3] = '{8, 4, 8};
    localparam int M[3] = '{1, 1, 0};

    logic        clk;
    logic        rst;
    logic [3:0]  i_evt;
    logic [3:0]  i_ack;
    logic [3:0]  i_mask;
    logic [3:0]  i_clr_cnt;

    logic [3:0]  pend_a, pend_b, pend_c;
    logic        irq_a, irq_b, irq_c;
    logic [31:0] miss_a;
    logic [15:0] miss_b;
    logic [31:0] miss_c;

    int n_vec = 0;
    int n_err = 0;

    bit m_pend[3][4];
    int m_cnt[3][4];
    bit m_prev[3][4];
`ifdef BOT_EVT_SYNC_IN_EN
    logic [3:0] s1, s2;
`endif

    bot_evt_sync #(.N_CH(4), .CNT_W(8), .EDGE_MODE(1)) dut_a (
        .clk(clk), .rst(rst), .i_evt(i_evt), .i_ack(i_ack), .i_mask(i_mask),
        .i_clr_cnt(i_clr_cnt), .o_pending(pend_a), .o_irq(irq_a), .o_miss_cnt(miss_a));

    bot_evt_sync #(.N_CH(4), .CNT_W(4), .EDGE_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .i_evt(i_evt), .i_ack(i_ack), .i_mask(i_mask),
        .i_clr_cnt(i_clr_cnt), .o_pending(pend_b), .o_irq(irq_b), .o_miss_cnt(miss_b));

    bot_evt_sync #(.N_CH(4), .CNT_W(8), .EDGE_MODE(0)) dut_c (
        .clk(clk), .rst(rst), .i_evt(i_evt), .i_ack(i_ack), .i_mask(i_mask),
        .i_clr_cnt(i_clr_cnt), .o_pending(pend_c), .o_irq(irq_c), .o_miss_cnt(miss_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the reference behaviour, using the inputs present at the edge.
    task automatic model_update();
        logic [3:0] x;
        bit ev, miss;
        if (rst) begin
            for (int k = 0; k < 3; k++)
                for (int c = 0; c < 4; c++) begin
                    m_pend[k][c] = 1'b0;
                    m_cnt[k][c]  = 0;
                    m_prev[k][c] = 1'b1;
                end
`ifdef BOT_EVT_SYNC_IN_EN
            s1 = 4'hF;
            s2 = 4'hF;
`endif
        end else begin
`ifdef BOT_EVT_SYNC_IN_EN
            x  = s2;
            s2 = s1;
            s1 = i_evt;
`else
            x = i_evt;
`endif
            for (int k = 0; k < 3; k++)
                for (int c = 0; c < 4; c++) begin
                    ev   = (M[k] != 0) ? (x[c] && !m_prev[k][c]) : x[c];
                    miss = ev && m_pend[k][c] && !i_ack[c];
                    if (i_clr_cnt[c])
                        m_cnt[k][c] = miss ? 1 : 0;
                    else if (miss && m_cnt[k][c] < (1 << W[k]) - 1)
                        m_cnt[k][c] = m_cnt[k][c] + 1;
                    if (ev)            m_pend[k][c] = 1'b1;
                    else if (i_ack[c]) m_pend[k][c] = 1'b0;
                    m_prev[k][c] = x[c];
                end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            logic [3:0]  ep;
            logic [31:0] em;
            ep = 4'h0;
            em = 32'h0;
            for (int c = 0; c < 4; c++) begin
                ep[c] = m_pend[k][c];
                em    = em | (32'(m_cnt[k][c]) << (c * W[k]));
            end
            case (k)
                0: begin
                    chk("pend_a", 32'(pend_a), 32'(ep));
                    chk("irq_a",  32'(irq_a),  32'(|(ep & ~i_mask)));
                    chk("miss_a", miss_a, em);
                end
                1: begin
                    chk("pend_b", 32'(pend_b), 32'(ep));
                    chk("irq_b",  32'(irq_b),  32'(|(ep & ~i_mask)));
                    chk("miss_b", 32'(miss_b), em);
                end
                default: begin
                    chk("pend_c", 32'(pend_c), 32'(ep));
                    chk("irq_c",  32'(irq_c),  32'(|(ep & ~i_mask)));
                    chk("miss_c", miss_c, em);
                end
            endcase
        end
    endtask

    task automatic step(input logic [3:0] evt, input logic [3:0] ack, input logic [3:0] mask,
                        input logic [3:0] clr, input logic r);
        i_evt     = evt;
        i_ack     = ack;
        i_mask    = mask;
        i_clr_cnt = clr;
        rst       = r;
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input logic [3:0] mask);
        repeat (n) step(4'h0, 4'h0, mask, 4'h0, 1'b0);
    endtask

    initial begin
        i_evt = 4'h0; i_ack = 4'h0; i_mask = 4'h0; i_clr_cnt = 4'h0; rst = 1'b1;

        // Reset release with i_evt[0] already high: no event in edge mode.
        step(4'h1, 4'h0, 4'h0, 4'h0, 1'b1);
        step(4'h1, 4'h0, 4'h0, 4'h0, 1'b1);
        repeat (10) begin
            step(4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
            chk("t1_hold_pend0", 32'(pend_a[0]), 32'd0);
        end
        step(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        step(4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
        repeat (3) step(4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
        chk("t1_rise_pend0", 32'(pend_a[0]), 32'd1);
        step(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        step(4'h0, 4'h1, 4'h0, 4'h0, 1'b0);
        idle(3, 4'h0);
        chk("t1_ack_pend0", 32'(pend_a[0]), 32'd0);

        // Single pulse then ack on channel 1.
        step(4'h2, 4'h0, 4'h0, 4'h0, 1'b0);
        idle(3, 4'h0);
        chk("t2_pend1", 32'(pend_a[1]), 32'd1);
        chk("t2_irq",   32'(irq_a),     32'd1);
        step(4'h0, 4'h2, 4'h0, 4'h0, 1'b0);
        idle(1, 4'h0);
        chk("t2_ack_pend1", 32'(pend_a[1]), 32'd0);
        chk("t2_ack_irq",   32'(irq_a),     32'd0);

        // Event and ack together while pending: stays pending, no miss.
        step(4'h4, 4'h0, 4'h0, 4'h0, 1'b0);
        idle(3, 4'h0);
        step(4'h4, 4'h4, 4'h0, 4'h0, 1'b0);
        idle(3, 4'h0);
`ifndef BOT_EVT_SYNC_IN_EN
        chk("t3_pend2", 32'(pend_a[2]), 32'd1);
        chk("t3_miss2", 32'(miss_a[23:16]), 32'd0);
`endif
        step(4'h0, 4'h4, 4'h0, 4'h0, 1'b0);
        idle(1, 4'h0);

        // 20 events on channel 3 with no ack: 19 misses, 4-bit counter saturates.
        repeat (20) begin
            step(4'h8, 4'h0, 4'h0, 4'h0, 1'b0);
            step(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        end
        idle(3, 4'h0);
        chk("t4_sat_b",  32'(miss_b[15:12]), 32'd15);
        chk("t4_cnt_a",  32'(miss_a[31:24]), 32'd19);
        step(4'h0, 4'h0, 4'h0, 4'h8, 1'b0);
        idle(1, 4'h0);
        chk("t4_clr_b",  32'(miss_b[15:12]), 32'd0);
        chk("t4_clr_a",  32'(miss_a[31:24]), 32'd0);
        step(4'h0, 4'h8, 4'h0, 4'h0, 1'b0);

        // All channels masked: pending latches, irq suppressed until unmasked.
        step(4'h0, 4'h0, 4'hF, 4'h0, 1'b0);
        step(4'hF, 4'h0, 4'hF, 4'h0, 1'b0);
        idle(3, 4'hF);
        chk("t5_pend_all", 32'(pend_a), 32'hF);
        chk("t5_irq_masked", 32'(irq_a), 32'd0);
        i_mask = 4'hE;
        #1;
        chk("t5_irq_unmask0", 32'(irq_a), 32'd1);
        step(4'h0, 4'hF, 4'hE, 4'h0, 1'b0);
        idle(1, 4'h0);

        // Level mode: 5 cycles high from idle -> 1 set + 4 misses; then reset.
        step(4'h0, 4'hF, 4'h0, 4'hF, 1'b0);
        idle(1, 4'h0);
        repeat (5) step(4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
        idle(3, 4'h0);
        chk("t6_pend_c0", 32'(pend_c[0]), 32'd1);
        chk("t6_miss_c0", 32'(miss_c[7:0]), 32'd4);
        step(4'h5, 4'h0, 4'h0, 4'h0, 1'b1);
        chk("t6_rst_pend_c", 32'(pend_c), 32'd0);
        chk("t6_rst_miss_c", miss_c, 32'd0);
        chk("t6_rst_irq_a", 32'(irq_a), 32'd0);
        step(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

        // Randomised traffic against the model.
        repeat (400) begin
            step(4'($urandom), 4'($urandom & $urandom), 4'($urandom),
                 4'($urandom & $urandom & $urandom), ($urandom_range(63, 0) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
